// File: rtl/div8_seq_pkg.sv
// div8_seq shared definitions: state encodings, width and iteration count.
// Imported by div8_seq; optional DIV8_DIVZERO_EN lives in the top.
package div8_seq_pkg;

    localparam int DIV8_W    = 8;
    localparam int DIV8_ITER = 8;

    localparam logic [2:0] DIV8_LAST = 3'(DIV8_ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div8_state_t;

endpackage

// File: rtl/div8_seq_selectadd.sv
// selectAdd8: 8-bit carry-select adder, low nibble ripple,
// high nibble precomputed for both carries and muxed on c4.
module selectAdd8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

    assign sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    assign cout = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/div8_seq.sv
// div8_seq: 8-bit unsigned restoring divider, one quotient bit/clock.
// Optional DIV8_DIVZERO_EN: div_by_zero port and 1-cycle zero-divisor path.
module div8_seq
    import div8_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DIV8_W-1:0] dividend,
    input  logic [DIV8_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DIV8_W-1:0] quotient,
    output logic [DIV8_W-1:0] remainder
`ifdef DIV8_DIVZERO_EN
    ,
    output logic              div_by_zero
`endif
);

    div8_state_t state_q;
    div8_state_t state_d;

    logic [DIV8_W-1:0] d_q;
    logic [DIV8_W-1:0] v_q;
    logic [DIV8_W:0]   r_q;
    logic [2:0]        cnt_q;

    logic              accept;
    logic              dz_req;
    logic [DIV8_W:0]   r_sh;
    logic [DIV8_W-1:0] diff;
    logic              cout;
    logic              ge;
    logic [DIV8_W-1:0] d_nxt;
    logic [DIV8_W-1:0] r_nxt;

    assign accept = start && (state_q != RUN);

`ifdef DIV8_DIVZERO_EN
    assign dz_req = (divisor == '0);
`else
    assign dz_req = 1'b0;
`endif

    assign r_sh  = {r_q[DIV8_W-1:0], d_q[DIV8_W-1]};
    assign ge    = r_sh[DIV8_W] | cout;
    assign d_nxt = {d_q[DIV8_W-2:0], ge};
    assign r_nxt = ge ? diff : r_sh[DIV8_W-1:0];

    selectAdd8 u_sub (
        .a    (r_sh[DIV8_W-1:0]),
        .b    (~v_q),
        .cin  (1'b1),
        .sum  (diff),
        .cout (cout)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next-state: start accepted in IDLE/DONE, RUN ends on the last iteration
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = dz_req ? DONE : RUN;
            RUN:  if (cnt_q == DIV8_LAST) state_d = DONE;
            DONE: begin
                if (start) state_d = dz_req ? DONE : RUN;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // operand capture, shift/subtract iteration and result registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d_q       <= '0;
            v_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV8_DIVZERO_EN
            div_by_zero <= 1'b0;
`endif
        end else if (accept) begin
            d_q   <= dividend;
            v_q   <= divisor;
            r_q   <= '0;
            cnt_q <= '0;
`ifdef DIV8_DIVZERO_EN
            div_by_zero <= dz_req;
            if (dz_req) begin
                quotient  <= '1;
                remainder <= dividend;
            end
`endif
        end else if (state_q == RUN) begin
            d_q   <= d_nxt;
            r_q   <= {1'b0, r_nxt};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == DIV8_LAST) begin
                quotient  <= d_nxt;
                remainder <= r_nxt;
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
